dmem_responder: RTL and testbench

//  Memory-side responder for the CPU's load/store port (MEM stage). Accepts one

---
 rtl/dmem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU load/store port.
// Accepts one request at a time, performs an RV32I load or store on a
// word-organised array after LATENCY cycles in WAIT, and returns the
// result on a valid/ready response channel.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/req_ready      request handshake (req_ready high only in IDLE)
//   req_we, req_funct3       store/load select, RV32I size/signedness
//   req_addr, req_wdata      byte address, right-aligned store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       extended load data (0 for stores/errors), error flag
//
// Build option: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses respond with rsp_err=1
//   undefined -> misaligned accesses are aligned down, no error

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            valid_q, valid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // Address bits above the array span are ignored (wrap-around).
    logic unused_addr_c;
    assign unused_addr_c = ^req_addr[31:AW+2];

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Access operands: live inputs when the access commits on the accept edge.
    logic            acc_we_c;
    logic [2:0]      acc_f3_c;
    logic [AW+1:0]   acc_addr_c;
    logic [31:0]     acc_wdata_c;

    always_comb begin
        if (LATENCY == 0) begin
            acc_we_c    = req_we;
            acc_f3_c    = req_funct3;
            acc_addr_c  = req_addr[AW+1:0];
            acc_wdata_c = req_wdata;
        end else begin
            acc_we_c    = we_q;
            acc_f3_c    = f3_q;
            acc_addr_c  = addr_q;
            acc_wdata_c = wdata_q;
        end
    end

    // Decode: legality, alignment, lane selection, load extension, store merge.
    logic            legal_c;
    logic            misalign_c;
    logic            err_c;
    logic [AW+1:0]   eff_addr_c;
    logic [AW-1:0]   idx_c;
    logic [1:0]      off_c;
    logic [31:0]     word_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [31:0]     load_c;
    logic [31:0]     wr_word_c;

    always_comb begin
        legal_c = 1'b0;
        case (acc_f3_c)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = !acc_we_c;
            default:                legal_c = 1'b0;
        endcase

        misalign_c = ((acc_f3_c[1:0] == 2'b01) && acc_addr_c[0]) ||
                     ((acc_f3_c[1:0] == 2'b10) && (acc_addr_c[1:0] != 2'b00));

        eff_addr_c = acc_addr_c;
`ifdef DMEM_MISALIGN_TRAP_EN
        err_c = !legal_c || misalign_c;
`else
        err_c = !legal_c;
        if (acc_f3_c[1:0] == 2'b01) eff_addr_c[0]   = 1'b0;
        if (acc_f3_c[1:0] == 2'b10) eff_addr_c[1:0] = 2'b00;
`endif

        idx_c  = eff_addr_c[AW+1:2];
        off_c  = eff_addr_c[1:0];
        word_c = mem_q[idx_c];
        byte_c = word_c[{off_c, 3'b000} +: 8];
        half_c = off_c[1] ? word_c[31:16] : word_c[15:0];

        case (acc_f3_c)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'h0, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'h0, half_c};
            3'b010:  load_c = word_c;
            default: load_c = 32'h0;
        endcase

        wr_word_c = word_c;
        case (acc_f3_c[1:0])
            2'b00: wr_word_c[{off_c, 3'b000} +: 8] = acc_wdata_c[7:0];
            2'b01: begin
                if (off_c[1]) wr_word_c[31:16] = acc_wdata_c[15:0];
                else          wr_word_c[15:0]  = acc_wdata_c[15:0];
            end
            2'b10:   wr_word_c = acc_wdata_c;
            default: wr_word_c = word_c;
        endcase
    end

    // Next-state and response logic.
    logic commit_c;
    logic mem_we_c;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        valid_d  = valid_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        commit_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        commit_c = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Response payload is latched once at commit and held through RESP.
        if (commit_c) begin
            valid_d = 1'b1;
            err_d   = err_c;
            rdata_d = (acc_we_c || err_c) ? 32'h0 : load_c;
        end
    end

    assign mem_we_c = commit_c && acc_we_c && !err_c;

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset, but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_c) begin
            mem_q[idx_c] <= wr_word_c;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Inputs are driven and outputs sampled on the falling clock edge.
// Latency is counted as rising edges from the accept edge (inclusive)
// until rsp_valid is seen high, which must equal LATENCY+1.

module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Issue one request, wait for its response and complete the handshake.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd,
                          output logic er, output int lat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_cmp++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT + 1); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_rsp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT + 1); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rsp: got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 32'h10, 32'h0, rd, er, lat);
        do_req(1'b1, 3'b000, 32'h13, 32'h12345680, rd, er, lat);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_0x13: got %h want ffffff80", rd); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_0x13: got %h want 00000080", rd); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h80000000) begin n_fail++; $display("FAIL lw_after_sb: got %h want 80000000", rd); end
        do_req(1'b1, 3'b010, 32'h20, 32'h0, rd, er, lat);
        do_req(1'b1, 3'b001, 32'h22, 32'h7777BEEF, rd, er, lat);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh_0x22: got %h want ffffbeef", rd); end
        do_req(1'b0, 3'b101, 32'h22, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_0x22: got %h want 0000beef", rd); end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hBEEF0000) begin n_fail++; $display("FAIL lw_after_sh: got %h want beef0000", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        // Offer a competing store while the response is stalled.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); end
            n_cmp++; if (rsp_rdata !== 32'h80000000) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h want 80000000", i, rsp_rdata); end
            n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", rsp_valid); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h80000000) begin n_fail++; $display("FAIL bp_store_ignored: got %h want 80000000", rd); end
    endtask

    task automatic test_misalign_illegal();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat);
        do_req(1'b0, 3'b001, 32'h21, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL lh_0x21: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
`else
        n_cmp++; if (er !== 1'b0 || rd !== 32'hFFFFF00D) begin n_fail++; $display("FAIL lh_0x21: got err=%b rdata=%h want err=0 rdata=fffff00d", er, rd); end
`endif
        do_req(1'b0, 3'b010, 32'h22, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL lw_0x22: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
`else
        n_cmp++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lw_0x22: got err=%b rdata=%h want err=0 rdata=cafef00d", er, rd); end
`endif
        do_req(1'b1, 3'b011, 32'h20, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_f3_011: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
        n_cmp++; if (lat !== LAT + 1) begin n_fail++; $display("FAIL illegal_latency: got %0d want %0d", lat, LAT + 1); end
        do_req(1'b0, 3'b110, 32'h20, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL load_f3_110: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL word_unchanged: got err=%b rdata=%h want err=0 rdata=cafef00d", er, rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int seen = 0;
        do_req(1'b1, 3'b010, 32'h40, 32'h0BADF00D, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_rsp: got %0d valid cycles want 0", seen); end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rst_mid_word: got %h want 0badf00d", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, DEPTH * 4 + 4, 32'hA5A5A5A5, rd, er, lat);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wrap_lw_0x4: got %h want a5a5a5a5", rd); end
        do_req(1'b0, 3'b010, 32'hFFFFF004, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wrap_lw_high: got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_back_to_back();
        int first = -1; int second = -1;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'h0;
        for (int c = 0; c < 16 && second < 0; c++) begin
            if (req_ready) begin
                if (first < 0) first = c;
                else second = c;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (second - first !== LAT + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", second - first, LAT + 2); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_backpressure();
        test_misalign_illegal();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
